ysyx_220066_mdu_seq: RTL

YSYX_220066_MDU_SEQ -- requirements
Module: ysyx_220066_mdu_seq

---
 rtl/ysyx_220066_mdu_seq_pkg.sv | 52 +++++
 rtl/ysyx_220066_mdu_seq_if.sv | 28 ++
 rtl/ysyx_220066_mdu_seq_addsub.sv | 18 +
 rtl/ysyx_220066_mdu_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_220066_mdu_seq_pkg.sv
// Shared ysyx_220066 definitions: MDU op and state encodings, ALU control encodings, helpers.
// Contents: mdu_op_e (RV64M funct3), mdu_state_e (MDU FSM), alu_ctrl_e (ALU control),
//           sext32/zext32/magnitude helper functions.
package ysyx_220066_mdu_seq_pkg;

  // RV64M funct3 encodings.
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  // ALU control encodings used by the integer pipe.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_e;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] zext32(input logic [31:0] x);
    return {32'd0, x};
  endfunction

  // Absolute value of a two's-complement operand whose sign is 'neg'.
  function automatic logic [63:0] magnitude(input logic [63:0] x, input logic neg);
    return neg ? (64'd0 - x) : x;
  endfunction

endpackage

// File: rtl/ysyx_220066_mdu_seq_if.sv
// Request/response bundle between the issue logic and the sequential MDU.
// Request: in_valid/in_ready, op, word, src1, src2, flush. Response: out_valid/out_ready, result.
// Status: busy. master = requester side, slave = MDU side.
interface ysyx_220066_mdu_seq_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, word, src1, src2, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, word, src1, src2, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_220066_mdu_seq_addsub.sv
// Shared W-bit adder/subtractor, the single arithmetic unit of the MDU datapath.
// Ports: a, b (operands), sub (1: a - b, 0: a + b), sum (W bits), cout (carry out;
//        for subtraction cout=1 means a >= b unsigned, i.e. no borrow).
module ysyx_220066_MDU_addsub #(
  parameter int W = 65
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
  assign sum  = full[W-1:0];
  assign cout = full[W];
endmodule

// File: rtl/ysyx_220066_mdu_seq.sv
// Sequential RV64M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Ports: clk, rst_n (async active-low), io (slave modport of ysyx_220066_mdu_seq_if).
// Latency N+2 cycles from accept (N=64, or 32 for W ops); 2 cycles for div-by-zero/overflow.
module ysyx_220066_mdu_seq
  import ysyx_220066_mdu_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_220066_mdu_seq_if.slave io
);

  mdu_state_e      state_q, state_d;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q, result_q;
  mdu_op_e         op_q;
  logic            word_q, sign1_q, neg_q, dbz_q, ovf_q, out_valid_q;

  // ---------------- request decode ----------------
  mdu_op_e         op_in;
  logic            is_div_in, s1_signed, s2_signed, n1, n2, dbz_in, ovf_in, special_in;
  logic [XLEN-1:0] ext1, ext2, mag1, mag2, min_neg;
  logic            accept, in_ready, busy;

  always_comb begin
    op_in     = mdu_op_e'(io.op);
    is_div_in = io.op[2];
    // Low-half multiplies (MUL and every W multiply) ignore signs: the low bits are identical.
    s1_signed = is_div_in ? ~io.op[0]
                          : (~io.word & ((op_in == MDU_MULH) | (op_in == MDU_MULHSU)));
    s2_signed = is_div_in ? ~io.op[0] : (~io.word & (op_in == MDU_MULH));
    ext1 = io.word ? (s1_signed ? sext32(io.src1[31:0]) : zext32(io.src1[31:0])) : io.src1;
    ext2 = io.word ? (s2_signed ? sext32(io.src2[31:0]) : zext32(io.src2[31:0])) : io.src2;
    n1   = s1_signed & ext1[XLEN-1];
    n2   = s2_signed & ext2[XLEN-1];
    mag1 = magnitude(ext1, n1);
    mag2 = magnitude(ext2, n2);
    min_neg    = io.word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    dbz_in     = is_div_in & (ext2 == '0);
    ovf_in     = is_div_in & s1_signed & (ext2 == '1) & (ext1 == min_neg);
    special_in = dbz_in | ovf_in;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      MDU_IDLE: begin
        busy     = 1'b0;
        in_ready = ~io.flush;
        if (io.in_valid & ~io.flush) state_d = special_in ? MDU_FIX : MDU_CALC;
      end
      MDU_CALC: if (cnt_q == 6'd0) state_d = MDU_FIX;
      MDU_FIX:  state_d = MDU_DONE;
      MDU_DONE: if (io.out_ready) state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
    if (io.flush) state_d = MDU_IDLE;
  end

  assign accept = io.in_valid & in_ready;

  // ---------------- shared adder ----------------
  logic [XLEN:0]   add_a, add_b, add_sum;
  logic            add_sub, add_cout;
  logic            q_rem, q_mullo, q_mulh, fix_neg;
  logic [XLEN-1:0] fix_sel, fix_val, fix_result;

  always_comb begin
    q_rem   = op_q[2] & op_q[1];
    q_mullo = ~op_q[2] & ((op_q == MDU_MUL) | word_q);
    q_mulh  = ~op_q[2] & ~q_mullo;
    fix_neg = q_rem ? sign1_q : (~q_mullo & neg_q);
    // After 32 multiply steps the low product word sits in lo_q[63:32].
    if (q_mulh | q_rem)        fix_sel = hi_q;
    else if (q_mullo & word_q) fix_sel = zext32(lo_q[63:32]);
    else                       fix_sel = lo_q;
  end

  ysyx_220066_MDU_addsub #(.W(XLEN + 1)) u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    if (state_q == MDU_CALC) begin
      add_b = {1'b0, opb_q};
      if (op_q[2]) begin
        // Restoring trial subtraction of the shifted partial remainder.
        add_a   = {hi_q, lo_q[XLEN-1]};
        add_sub = 1'b1;
      end else begin
        add_a = {1'b0, hi_q};
      end
    end else if (state_q == MDU_FIX) begin
      // Negation: 0 - x. For the high product half, -P_hi = ~hi when lo != 0 (borrow
      // from the low half), i.e. all-ones - hi; otherwise 0 - hi.
      add_a   = q_mulh ? {(XLEN + 1){|lo_q}} : '0;
      add_b   = {1'b0, fix_sel};
      add_sub = 1'b1;
    end
  end

  always_comb begin
    fix_val = fix_neg ? add_sum[XLEN-1:0] : fix_sel;
    // Special cases keep the extended dividend in lo_q.
    if (dbz_q)      fix_val = q_rem ? lo_q : '1;
    else if (ovf_q) fix_val = q_rem ? '0 : lo_q;
    fix_result = word_q ? sext32(fix_val[31:0]) : fix_val;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      op_q        <= MDU_MUL;
      word_q      <= 1'b0;
      sign1_q     <= 1'b0;
      neg_q       <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        MDU_IDLE: if (accept) begin
          op_q    <= op_in;
          word_q  <= io.word;
          sign1_q <= n1;
          neg_q   <= n1 ^ n2;
          dbz_q   <= dbz_in;
          ovf_q   <= ovf_in;
          cnt_q   <= io.word ? 6'd31 : 6'd63;
          hi_q    <= '0;
          if (special_in) begin
            lo_q  <= ext1;
            opb_q <= '0;
          end else if (is_div_in) begin
            // W divides start with the 32-bit dividend at the top so it shifts out first.
            lo_q  <= io.word ? {mag1[31:0], 32'd0} : mag1;
            opb_q <= mag2;
          end else begin
            lo_q  <= mag2;
            opb_q <= mag1;
          end
        end
        MDU_CALC: begin
          cnt_q <= cnt_q - 6'd1;
          if (op_q[2]) begin
            if (add_cout) begin
              hi_q <= add_sum[XLEN-1:0];
              lo_q <= {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_q <= {hi_q[XLEN-2:0], lo_q[XLEN-1]};
              lo_q <= {lo_q[XLEN-2:0], 1'b0};
            end
          end else if (lo_q[0]) begin
            hi_q <= add_sum[XLEN:1];
            lo_q <= {add_sum[0], lo_q[XLEN-1:1]};
          end else begin
            hi_q <= {1'b0, hi_q[XLEN-1:1]};
            lo_q <= {hi_q[0], lo_q[XLEN-1:1]};
          end
        end
        default: ;
      endcase
      if ((state_q == MDU_FIX) && !io.flush) result_q <= fix_result;
      out_valid_q <= (state_d == MDU_DONE);
    end
  end

  assign io.in_ready  = in_ready;
  assign io.busy      = busy;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;

endmodule
